threshold_monitor: RTL

THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

---
 rtl/threshold_monitor_pkg.sv | 18 +
 rtl/threshold_monitor_mag_cmp.sv | 16 +
 rtl/threshold_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/threshold_monitor_pkg.sv
// Shared FSM state encoding, event codes and widths for threshold_monitor.
package threshold_monitor_pkg;

  typedef enum logic [1:0] {
    ST_BELOW      = 2'd0,
    ST_CONFIRM_UP = 2'd1,
    ST_ABOVE      = 2'd2,
    ST_CONFIRM_DN = 2'd3
  } state_t;

  localparam logic [1:0] EVT_NONE = 2'b00;
  localparam logic [1:0] EVT_RISE = 2'b01;
  localparam logic [1:0] EVT_FALL = 2'b10;

  localparam int CNT_W   = 4;
  localparam int STATS_W = 16;

endpackage

// File: rtl/threshold_monitor_mag_cmp.sv
// Purely combinational unsigned magnitude comparator (a versus b).
module mag_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/threshold_monitor.sv
// Debounced hysteresis threshold monitor with valid/ready sample input and event output.
// Optional THRESHOLD_MONITOR_STATS_EN adds a saturating 16-bit accepted-event counter.
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic             level_hi,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type
`ifdef THRESHOLD_MONITOR_STATS_EN
  ,
  output logic [STATS_W-1:0] evt_count
`endif
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             evt_valid_reg, evt_valid_next;
  logic [1:0]       evt_type_reg, evt_type_next;
  logic             level_hi_reg, level_hi_next;
  logic             accept;

  // Index 0 compares against thr_hi, index 1 against thr_lo.
  logic [WIDTH-1:0] thr [2];
  logic [1:0]       cmp_gt, cmp_eq, cmp_lt;
  logic             unused_cmp;

  assign thr[0] = thr_hi;
  assign thr[1] = thr_lo;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmp
      mag_cmp #(.WIDTH(WIDTH)) u_mag_cmp (
        .a  (in_data),
        .b  (thr[gi]),
        .gt (cmp_gt[gi]),
        .eq (cmp_eq[gi]),
        .lt (cmp_lt[gi])
      );
    end
  endgenerate

  assign unused_cmp = &{1'b0, cmp_gt[1], cmp_lt[0], cmp_eq};

  assign in_ready  = !evt_valid_reg;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_reg + CNT_W'(1);
  assign evt_valid = evt_valid_reg;
  assign evt_type  = evt_type_reg;
  assign level_hi  = level_hi_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    evt_valid_next = evt_valid_reg;
    evt_type_next  = evt_type_reg;
    level_hi_next  = level_hi_reg;

    if (evt_valid_reg && evt_ready) begin
      evt_valid_next = 1'b0;
      evt_type_next  = EVT_NONE;
    end

    // accept implies no event is pending, so a new event never collides with a clear.
    if (accept) begin
      case (state_reg)
        ST_BELOW, ST_CONFIRM_UP: begin
          if (cmp_gt[0]) begin
            if ((state_reg == ST_BELOW ? CNT_W'(1) : cnt_inc) == DEB) begin
              state_next     = ST_ABOVE;
              cnt_next       = '0;
              evt_valid_next = 1'b1;
              evt_type_next  = EVT_RISE;
              level_hi_next  = 1'b1;
            end else begin
              state_next = ST_CONFIRM_UP;
              cnt_next   = (state_reg == ST_BELOW) ? CNT_W'(1) : cnt_inc;
            end
          end else begin
            state_next = ST_BELOW;
            cnt_next   = '0;
          end
        end
        ST_ABOVE, ST_CONFIRM_DN: begin
          if (cmp_lt[1]) begin
            if ((state_reg == ST_ABOVE ? CNT_W'(1) : cnt_inc) == DEB) begin
              state_next     = ST_BELOW;
              cnt_next       = '0;
              evt_valid_next = 1'b1;
              evt_type_next  = EVT_FALL;
              level_hi_next  = 1'b0;
            end else begin
              state_next = ST_CONFIRM_DN;
              cnt_next   = (state_reg == ST_ABOVE) ? CNT_W'(1) : cnt_inc;
            end
          end else begin
            state_next = ST_ABOVE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = ST_BELOW;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_BELOW;
      cnt_reg       <= '0;
      evt_valid_reg <= 1'b0;
      evt_type_reg  <= EVT_NONE;
      level_hi_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      evt_valid_reg <= evt_valid_next;
      evt_type_reg  <= evt_type_next;
      level_hi_reg  <= level_hi_next;
    end
  end

`ifdef THRESHOLD_MONITOR_STATS_EN
  logic [STATS_W-1:0] evt_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count_reg <= '0;
    end else if (evt_valid_reg && evt_ready && (evt_count_reg != {STATS_W{1'b1}})) begin
      evt_count_reg <= evt_count_reg + STATS_W'(1);
    end
  end

  assign evt_count = evt_count_reg;
`endif

endmodule
